dmem_access_ctrl: RTL

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Data-memory access sequencer for the MEM pipeline stage. It turns a MEM-stage
// load/store request into a registered memory handshake, holds the pipeline while
// the access is outstanding, and abandons the access if no ack arrives in time.
//
// Ports
//   clk            single clock, all state changes on posedge
//   rst            asynchronous reset, active low
//   MemRead_i      MEM-stage load request
//   MemWrite_i     MEM-stage store request (wins over MemRead_i)
//   addr_i         byte address from EX/MEM
//   wdata_i        store data
//   mem_req_o      registered memory request
//   mem_we_o       registered write enable (1 = store)
//   mem_addr_o     registered address, stable while mem_req_o = 1
//   mem_wdata_o    registered store data, stable while mem_req_o = 1
//   mem_ack_i      one-cycle completion pulse from memory
//   mem_rdata_i    load data, valid with mem_ack_i
//   stall_o        freezes PC, IF/ID, ID/EX, EX/MEM
//   bubble_o       squashes RegWrite/MemtoReg into MEM/WB
//   rdata_o        registered load data for MEM/WB
//   rdata_valid_o  rdata_o carries fresh load data this cycle
//   err_o          sticky timeout flag, cleared only by reset
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        bubble_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        err_o
);

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e      r_state, w_state_d;
  logic        r_req, w_req_d;
  logic        r_we, w_we_d;
  logic [31:0] r_addr, w_addr_d;
  logic [31:0] r_wdata, w_wdata_d;
  logic [31:0] r_rdata, w_rdata_d;
  logic        r_rvalid, w_rvalid_d;
  logic        r_err, w_err_d;
  // Marks that the access now in DONE ended by timeout; err_o alone cannot say
  // this because it is sticky across later accesses.
  logic        r_to, w_to_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic [7:0]  w_cnt_inc;
  logic        w_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_to     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_req    <= w_req_d;
      r_we     <= w_we_d;
      r_addr   <= w_addr_d;
      r_wdata  <= w_wdata_d;
      r_rdata  <= w_rdata_d;
      r_rvalid <= w_rvalid_d;
      r_err    <= w_err_d;
      r_to     <= w_to_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    w_state_d  = r_state;
    w_req_d    = r_req;
    w_we_d     = r_we;
    w_addr_d   = r_addr;
    w_wdata_d  = r_wdata;
    w_rdata_d  = r_rdata;
    w_rvalid_d = r_rvalid;
    w_err_d    = r_err;
    w_to_d     = r_to;
    w_cnt_d    = r_cnt;
    w_stall    = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (MemRead_i || MemWrite_i) begin
          w_stall   = 1'b1;
          w_addr_d  = addr_i;
          w_wdata_d = wdata_i;
          w_we_d    = MemWrite_i;
          w_req_d   = 1'b1;
          w_cnt_d   = '0;
          w_to_d    = 1'b0;
          w_state_d = StBusy;
        end
      end
      StBusy: begin
        w_stall = 1'b1;
        // Ack is checked first so an ack on the final allowed cycle is a success.
        if (mem_ack_i) begin
          w_req_d   = 1'b0;
          if (!r_we) begin
            w_rdata_d  = mem_rdata_i;
            w_rvalid_d = 1'b1;
          end
          w_state_d = StDone;
        end else begin
          w_cnt_d = w_cnt_inc;
          if (w_cnt_inc == TimeoutVal) begin
            w_req_d   = 1'b0;
            w_rdata_d = '0;
            w_err_d   = 1'b1;
            w_to_d    = 1'b1;
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        // Requests seen here are ignored; the pipeline advances on this edge
        // and the next access is taken from IDLE.
        w_rvalid_d = 1'b0;
        w_state_d  = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign stall_o       = w_stall;
  assign bubble_o      = w_stall | ((r_state == StDone) & r_to);
  assign mem_req_o     = r_req;
  assign mem_we_o      = r_we;
  assign mem_addr_o    = r_addr;
  assign mem_wdata_o   = r_wdata;
  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_rvalid;
  assign err_o         = r_err;

endmodule
